// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant, rotating priority, and
// bounded hold so a continuously requesting port cannot starve the others.
module rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int MAX_HOLD  = 4,
    localparam int IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic                 gnt_vld_o,
    output logic [IDX_W-1:0]     gnt_idx_o
);

    localparam int                HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0]  LAST_PORT = IDX_W'(NUM_PORTS - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]           state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     owner;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [NUM_PORTS-1:0] gnt;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     win_next_ptr;
    logic                 keep_owner;

    // Port index "offset" places after base, wrapping with an explicit compare
    // so non-power-of-two port counts rotate correctly.
    function automatic logic [IDX_W-1:0] rotate(input logic [IDX_W-1:0] base,
                                                 input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
        return IDX_W'(sum);
    endfunction

    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!win_found && req_i[rotate(ptr, i)]) begin
                win_found = 1'b1;
                win_idx   = rotate(ptr, i);
            end
        end
    end

    assign win_next_ptr = (win_idx == LAST_PORT) ? '0 : win_idx + 1'b1;

    // hold_cnt never exceeds HOLD_LAST, so != is equivalent to < here and
    // stays well-formed when MAX_HOLD is 1.
    assign keep_owner = (state == GRANT) && req_i[owner] && (hold_cnt != HOLD_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
        end else if (keep_owner) begin
            hold_cnt <= hold_cnt + 1'b1;
        end else if (win_found) begin
            state    <= GRANT;
            owner    <= win_idx;
            ptr      <= win_next_ptr;
            hold_cnt <= '0;
            gnt      <= NUM_PORTS'(1) << win_idx;
        end else begin
            state    <= IDLE;
            hold_cnt <= '0;
            gnt      <= '0;
        end
    end

    assign gnt_o     = gnt;
    assign gnt_vld_o = (state == GRANT);
    assign gnt_idx_o = owner;

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Parametrised round-robin arbiter with a registered one-hot grant and bounded grant hold. It generalises the combinational fixed-priority arbiter: priority rotates after every new grant, so no requester starves. A requester that keeps its request asserted may hold the grant for up to MAX_HOLD consecutive cycles. It sits in front of shared resources such as a bus, memory port or FIFO write side, where fairness and a glitch-free registered grant are required.

## Interface
- NUM_PORTS, default 4: number of requesters; legal range ≥ 1.
- MAX_HOLD, default 4: maximum consecutive cycles one port keeps the grant while requesting; legal range ≥ 1. A value of 1 gives pure per-cycle rotation.
- IDX_W, derived: max(1, $clog2(NUM_PORTS)); not user-set.

- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  reset, asynchronous, active-high.
- req_i  input  NUM_PORTS  request vector, bit k = port k.
- gnt_o  output  NUM_PORTS  registered one-hot grant; all-zero when idle.
- gnt_vld_o  output  1  high when any bit of gnt_o is high.
- gnt_idx_o  output  IDX_W  binary index of the granted port; holds its last value when gnt_vld_o is low.

## Operation
- State registers:
  - ptr (IDX_W): highest-priority port for the next fresh arbitration.
  - owner (IDX_W): currently granted port.
  - hold_cnt: cycles the current owner has held the grant, counting from 0.
  - gnt_o, gnt_vld_o.
- Two states:
  - IDLE: gnt_vld_o = 0.
  - GRANT: gnt_vld_o = 1, owner valid.
- At each rising edge, evaluate using req_i sampled at that edge:
  - **Hold rule.** In GRANT, if req_i[owner] = 1 and hold_cnt < MAX_HOLD-1: keep owner and increment hold_cnt. ptr is unchanged.
  - **Fresh arbitration.** Applies in every other case, including IDLE:
    - Search req_i starting at ptr, ascending, wrapping at NUM_PORTS-1 → 0. The first set bit k wins.
    - Set owner = k, gnt_o = one-hot(k), hold_cnt = 0, and ptr = (k+1) mod NUM_PORTS. The wrap uses an explicit compare; do not rely on power-of-2 truncation.
    - The expiring owner takes part in the search at its normal rotated priority. Because ptr has already advanced past it, it wins only if no other port requests. A sole requester therefore keeps the grant indefinitely, with hold_cnt restarting at 0.
  - **No request.** If req_i = 0: go to IDLE with gnt_o = 0. ptr and gnt_idx_o are unchanged and hold_cnt = 0.
- gnt_o is always one-hot or zero, and is driven only from flops.
- gnt_idx_o is always equal to owner.
- NUM_PORTS = 1: the block degenerates to gnt_o = req_i delayed one cycle; ptr stays 0.

## Timing
- Reset values (applied asynchronously on assertion of reset):
  - gnt_o = 0, gnt_vld_o = 0, gnt_idx_o = 0.
  - ptr = 0, owner = 0, hold_cnt = 0; state IDLE.
- Latency: a request present at edge n produces a grant visible after edge n (one cycle). There is no combinational path from req_i to any output.
- Deassertion by the owner during cycle t is seen at the edge ending cycle t. gnt_o therefore stays on that port for cycle t and moves or clears afterwards. Consumers must qualify use of the grant with their own request.
- Request changes between edges are ignored; only the value at the edge matters.
- Reset during GRANT: the grant drops immediately. After release, arbitration restarts from port 0 at the first edge.
- Simultaneous hold expiry and new requests are handled by the fresh arbitration rule; there are no stall cycles between owners.
- Fairness bound: with all ports requesting, any port waits at most (NUM_PORTS-1)·MAX_HOLD cycles between grants.

## Test plan
All scenarios use NUM_PORTS=4 and MAX_HOLD=2 unless stated.

1. Release reset, then hold req_i=4'b1111 constantly → gnt_o repeats the sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001. gnt_idx_o follows 0,0,1,1,2,2,3,3,0.
2. Hold req_i=4'b0100 only → gnt_o=0100 every cycle from the first edge onward, continuing past hold expiry. The ptr value held internally is 3.
3. Port 1 is granted with req_i=4'b1010, then port 1 drops its request after one cycle → one more cycle of 0010, then 1000 for 2 cycles. Next, raising req_i=4'b1011 → grant goes to 0001 (ptr=0 after the port 3 grant).
4. Drive req_i=0 after a grant to port 2 → gnt_o=0 and gnt_vld_o=0, while gnt_idx_o stays 2. A subsequent req_i=4'b1111 → grant goes to port 3.
5. Assert reset mid-cycle while gnt_o=0100 → outputs clear without waiting for a clock edge. After release with req_i=4'b1111 → the first grant is 0001.
6. With MAX_HOLD=1 and NUM_PORTS=3, hold req_i=3'b111 → gnt_o rotates 001,010,100,001 every cycle. A bench assertion checks that gnt_o is one-hot or zero on every cycle.
